// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - data-RAM responder with programmable wait states
// Word-organised RAM behind the req/ready handshake; registered read data and range error pulse.
module dram_responder #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 4096,
  parameter int              WAIT_CYCLES = 0,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN/8-1:0] dram_wstrb,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  output logic              dram_ready,
  output logic [XLEN-1:0]   dram_rdata,
  output logic              dram_rvalid,
  output logic              dram_err
);

  localparam int              AW       = $clog2(DEPTH_WORDS);
  localparam int              NB       = XLEN / 8;
  localparam logic [XLEN-1:0] SPAN     = XLEN'(DEPTH_WORDS * 4);
  localparam logic [3:0]      CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [XLEN-1:0]   r_rdata;
  logic              r_rvalid;
  logic              r_err;
  logic [XLEN-1:0]   r_mem [DEPTH_WORDS];

  logic [XLEN-1:0]   w_offset;
  logic              w_in_range;
  logic [AW-1:0]     w_index;
  logic              w_ready;
  logic              w_fire;

  // Subtracting the base first makes addresses below BASE_ADDR wrap high and fail the compare.
  assign w_offset   = dram_addr - BASE_ADDR;
  assign w_in_range = w_offset < SPAN;
  assign w_index    = w_offset[AW+1:2];

  generate
    if (WAIT_CYCLES == 0) begin : g_nowait
      assign w_ready = dram_req & ~rst;
    end else begin : g_wait
      assign w_ready = dram_req & ~rst & (r_state == S_WAIT) & (r_cnt == 4'd0);
    end
  endgenerate

  assign w_fire      = dram_req & w_ready;
  assign dram_ready  = w_ready;
  assign dram_rdata  = r_rdata;
  assign dram_rvalid = r_rvalid;
  assign dram_err    = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_fire & ~dram_write;
      r_err    <= w_fire & ~w_in_range;
      if (w_fire && !dram_write) begin
        r_rdata <= w_in_range ? r_mem[w_index] : '0;
      end
      case (r_state)
        S_IDLE: begin
          if (dram_req && (WAIT_CYCLES != 0)) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (!dram_req) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_fire && dram_write && w_in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (dram_wstrb[i]) begin
          r_mem[w_index][8*i +: 8] <= dram_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Slave/responder end of the core data-RAM interface (dram_req/dram_write/dram_wstrb/dram_addr/dram_wdata/dram_ready) driven by the EX stage.
- Backs the interface with a word-organised on-chip RAM, with a programmable number of wait states.
- Returns registered read data to the MEM stage one cycle after the handshake.
- Flags out-of-range accesses.

Parameters:
- XLEN, 32, data/address width.
- DEPTH_WORDS, 4096, RAM depth in XLEN-bit words; power of two.
- WAIT_CYCLES, 0, extra cycles between request and ready (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- dram_req  in  1  access request; attributes stable while high.
- dram_write  in  1  1 = store, 0 = load.
- dram_wstrb  in  XLEN/8  byte write enables, lane i = bits [8i+7:8i].
- dram_addr  in  XLEN  byte address; bits [1:0] ignored for indexing.
- dram_wdata  in  XLEN  store data, already lane-replicated by initiator.
- dram_ready  out  1  handshake; access completes in cycle where dram_req & dram_ready.
- dram_rdata  out  XLEN  full word read data.
- dram_rvalid  out  1  one-cycle pulse: dram_rdata valid.
- dram_err  out  1  one-cycle pulse: completed access was out of range.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Handshake:
  - fire = dram_req & dram_ready, evaluated combinationally in the same cycle.
  - The initiator may deassert dram_req without a fire (pipeline flush). That aborts the access with no side effects.
- Decode:
  - in_range = (dram_addr - BASE_ADDR) < DEPTH_WORDS*4, computed as an unsigned XLEN-bit compare.
  - index = (dram_addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- FSM states: IDLE, WAIT.
- WAIT_CYCLES = 0:
  - No WAIT state; dram_ready = dram_req & ~rst, purely combinational.
  - Zero-wait back-to-back accesses fire every cycle.
- WAIT_CYCLES = N > 0:
  - IDLE & dram_req: load cnt = N-1, go to WAIT; dram_ready = 0.
  - WAIT & dram_req & cnt != 0: cnt decrements.
  - WAIT & dram_req & cnt == 0: dram_ready = 1 (combinational), fire, next state IDLE.
  - WAIT & ~dram_req: abort; next state IDLE, cnt cleared, no write, no rvalid.
  - The first fire occurs N cycles after req first seen.
  - After a fire the FSM returns to IDLE, so a following req held high restarts the N-cycle wait.
  - Throughput is one access per N+1 cycles.
- Write:
  - On a fire with dram_write = 1 and in_range, write lanes with dram_wstrb[i] = 1 at the clock edge ending the fire cycle.
  - wstrb = 0 writes nothing.
- Read:
  - On a fire with dram_write = 0, dram_rdata is registered at the same edge: RAM[index], or 0 if out of range.
  - dram_rvalid = 1 for exactly the next cycle.
  - dram_rdata holds its value until the next read fire.
- Read-after-write to the same word in consecutive fires returns the newly written data. The RAM is single-port, so no same-cycle conflict exists.
- Error:
  - A fire with ~in_range still completes normally (ready, no hang).
  - Writes are dropped; reads return 0.
  - dram_err pulses 1 in the cycle after the fire.
- Reset values: state = IDLE, cnt = 0, dram_ready = 0, dram_rvalid = 0, dram_err = 0, dram_rdata = 0.
- RAM contents are not reset.
- Reset mid-operation: reset in WAIT or in a fire cycle suppresses the write, ready, rvalid and err; the FSM is in IDLE the cycle after rst deasserts.
- dram_ready is never 1 while dram_req = 0.

Test Plan:
- Reset with WAIT_CYCLES = 0, hold rst 3 cycles with req=1 -> dram_ready=0, dram_rvalid=0, dram_rdata=0 throughout; ready follows req from the first cycle after reset.
- WAIT_CYCLES = 0: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF; next cycle read 0x10 -> ready same cycle as req; rvalid pulse next cycle with rdata 0xDEADBEEF.
- Byte write addr 0x12, wdata 0x5A5A5A5A, wstrb 4'b0100, then read 0x10 -> rdata 0xDE5ABEEF.
- WAIT_CYCLES = 2: hold read req at 0x10 -> ready high only in the 3rd req cycle; rvalid in the 4th; a continued req gets its next ready 3 cycles later.
- WAIT_CYCLES = 2: write req dropped after 1 cycle, then read same word -> no ready during the aborted write; memory unchanged; no rvalid from the abort.
- DEPTH_WORDS = 4096, BASE_ADDR = 0: read 0x4000 and write 0x4004 -> each fires, dram_err pulses after each; read rdata = 0; a later read of 0x4 returns its old contents.
